// File: rtl/icache_direct_if.sv
// icache_direct_if: groups the fetch-side and memory-side buses of the
// direct-mapped instruction cache.
//
// Fetch side (datapath <-> cache):
//   imemREN  : fetch request
//   imemaddr : fetch byte address, bits [1:0] ignored
//   ihit     : imemload holds the requested word this cycle
//   imemload : instruction word, 0 when ihit=0
//   flush    : invalidate every frame
// Memory side (cache <-> arbiter):
//   iREN     : read request
//   iaddr    : word-aligned read address, 0 when no request
//   iwait    : memory busy
//   iload    : read data
//
// Handshake: the cache raises iREN with a stable iaddr and holds both until a
// cycle where iwait=0; iload is consumed in exactly that cycle and iREN drops
// on the following cycle. ihit is a same-cycle response to imemREN and has no
// back-pressure of its own.
//
// Modports: slave = cache, master = the datapath/memory environment.
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-frame instruction cache.
// Hits are answered combinationally; a miss launches a fill (IDLE->FETCH)
// that writes the returned word into its frame, after which the lookup is
// repeated from IDLE. Flush invalidates all frames; saturating counters track
// hit cycles and miss events.
//
// Ports:
//   CLK         : rising-edge clock
//   RST         : synchronous active-high reset
//   bus         : icache_direct_if.slave (fetch and memory buses)
//   hit_cnt     : saturating count of cycles with ihit=1
//   miss_cnt    : saturating count of IDLE->FETCH transitions
//   o_dbg_fetch : 1 while the fill FSM is in FETCH
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic               CLK,
  input  logic               RST,
  icache_direct_if.slave     bus,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt,
  output logic               o_dbg_fetch
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  // Only the word address of the pending fill is kept.
  logic [31:2]       r_fill_addr;
  logic [15:0]       r_hit_cnt;
  logic [15:0]       r_miss_cnt;

  logic [IDX-1:0]    w_index;
  logic [TAGW-1:0]   w_tag;
  logic [IDX-1:0]    w_fill_index;
  logic [TAGW-1:0]   w_fill_tag;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_done;
  logic              w_unused_lo;

  assign w_index      = bus.imemaddr[IDX+1:2];
  assign w_tag        = bus.imemaddr[31:IDX+2];
  assign w_fill_index = r_fill_addr[IDX+1:2];
  assign w_fill_tag   = r_fill_addr[31:IDX+2];
  assign w_unused_lo  = ^bus.imemaddr[1:0];

  // Lookups are only honoured in IDLE, so a fill can never race a hit.
  assign w_hit  = (r_state == IDLE) & bus.imemREN & r_valid[w_index] &
                  (r_tag[w_index] == w_tag) & ~bus.flush;
  assign w_miss = (r_state == IDLE) & bus.imemREN & ~w_hit & ~bus.flush;
  // Flush aborts a fill even if the memory answers in the same cycle.
  assign w_fill_done = (r_state == FETCH) & ~bus.iwait & ~bus.flush;

  always_comb begin
    w_state_nxt  = r_state;
    bus.ihit     = 1'b0;
    bus.imemload = 32'h0;
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'h0;
    case (r_state)
      IDLE: begin
        bus.ihit     = w_hit;
        bus.imemload = w_hit ? r_data[w_index] : 32'h0;
        if (w_miss) w_state_nxt = FETCH;
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {r_fill_addr, 2'b00};
        if (bus.flush || !bus.iwait) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_fill_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss) r_fill_addr <= bus.imemaddr[31:2];
      if (bus.flush) begin
        r_valid <= '0;
      end else if (w_fill_done) begin
        r_valid[w_fill_index] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: a frame is only read when its valid bit
  // is set, and valid is only set together with a tag/data write.
  always_ff @(posedge CLK) begin
    if (!RST && w_fill_done) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= bus.iload;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != 16'hFFFF))   r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;
  assign o_dbg_fetch = (r_state == FETCH);

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, single-word-block instruction cache between the pipelined datapath's fetch stage (imemREN/imemaddr/imemload/ihit) and the memory arbiter's instruction port (iREN/iaddr/iload/iwait). It returns hits combinationally in the same cycle. On a miss it runs a fill FSM, writes the returned word into the frame, and then re-presents the hit. It also supports a whole-cache flush and keeps saturating hit/miss counters for performance bring-up.

## Interface
- SETS, 16, number of frames; power of two, at least 2; IDX = log2(SETS)
- CLK  in  1  rising-edge clock
- RST  in  1  reset; one clock, synchronous, active-high
- imemREN  in  1  fetch request from datapath
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  requested word valid on imemload this cycle
- imemload  out  32  instruction word; 0 when ihit=0
- flush  in  1  invalidate all frames
- iREN  out  1  memory read request
- iaddr  out  32  memory word address ({addr[31:2],2'b00})
- iwait  in  1  memory busy; iload valid in a cycle with iREN=1 and iwait=0
- iload  in  32  memory read data
- hit_cnt  out  16  count of cycles with ihit=1
- miss_cnt  out  16  count of miss events

## Operation
- Address fields:
  - index = imemaddr[IDX+1:2]
  - tag = imemaddr[31:IDX+2]
  - each frame holds valid, tag and data
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = imemREN & valid[index] & tag match & !flush
  - ihit = hit; imemload = data[index] when hit
  - A miss is imemREN & !hit & !flush. It latches fill_addr <= imemaddr and moves to FETCH.
  - iREN = 0 in IDLE.
- FETCH:
  - ihit = 0; iREN = 1; iaddr = fill_addr word-aligned.
  - When iwait=0: write the frame selected by fill_addr (data = iload, tag from fill_addr, valid = 1), then return to IDLE.
  - While iwait=1, the FSM stays in FETCH.
- The fill always targets the latched fill_addr. Changes to imemaddr or imemREN during FETCH have no effect on the fill in progress. After the return to IDLE, the current address is looked up fresh.
- Flush:
  - Clears every valid bit at the clock edge.
  - In IDLE: ihit is forced to 0 that cycle and no miss is launched.
  - In FETCH: flush aborts the fill. The frame is not written even if iwait=0 in that cycle, and the FSM returns to IDLE.
- Counters:
  - hit_cnt increments on every cycle with ihit=1.
  - miss_cnt increments on every IDLE→FETCH transition.
  - Both saturate at 16'hFFFF and are cleared only by RST.
- A replaced frame is overwritten unconditionally. There is no write path from the datapath, because instruction memory is read-only.

## Timing
- Reset (RST=1 at an edge): all valid bits cleared, state IDLE, fill_addr 0, counters 0. Resulting outputs: ihit 0, imemload 0, iREN 0, iaddr 0, hit_cnt 0, miss_cnt 0.
- RST has priority over flush, fills and counters, including when it is asserted mid-FETCH. A fill in progress is dropped and its frame is not written.
- Hit latency is 0 cycles (combinational from imemaddr).
- Miss with memory latency L, where L = the number of FETCH cycles with iwait=1:
  - cycle 0: miss detected
  - cycles 1..L+1: FETCH with iREN=1; frame written at the end of cycle L+1
  - cycle L+2: IDLE, ihit=1
  - Minimum miss penalty is 2 cycles (L=0).
- iaddr outside FETCH is driven to 0.
- Simultaneous events:
  - A fill completion and a lookup of the same index in the same cycle cannot occur, because ihit is 0 throughout FETCH.
  - Back-to-back misses to different indices each pay the full penalty.
  - A conflicting tag evicts the prior line with no stall beyond the miss penalty.

## Test plan
- Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 2 cycles then 0 with iload=0x2001_0005 -> iREN=1 and iaddr=0x40 for 3 cycles; then ihit=1 and imemload=0x2001_0005; miss_cnt=1.
- Repeat hit: re-request 0x40 for 4 cycles -> ihit=1 every cycle, iREN=0, hit_cnt increments by 4.
- Conflict eviction (SETS=16): fill 0x40, then request 0x440 (same index, different tag) -> miss and refill with the new word. A later request to 0x40 misses again; miss_cnt=3.
- Address change mid-fill: miss on 0x80, switch imemaddr to 0x84 while iwait=1 -> iaddr stays 0x80. The 0x80 frame is filled, then 0x84 misses and is fetched separately.
- Flush: fill 0x40 and 0x44, pulse flush for 1 cycle in IDLE -> that cycle ihit=0 with no miss launched; the next requests to 0x40 and 0x44 both miss. A flush during FETCH with iwait=0 leaves the frame invalid.
- Reset mid-fill: RST=1 while in FETCH -> next cycle iREN=0, counters 0, and the target address misses on the next request.
